fixmul: RTL and testbench
=========================

Name: fixmul

Overview:
- Registered fixed-point multiplier for unsigned (UQ) and two's-complement signed (SQ) operands.
- Both operands and the result share one Q format: TOTAL_BITS wide, FRACTIONAL_BITS fractional.
- Signedness is chosen per transaction.
- Used in the synth datapath for gain, envelope and amplitude scaling.
- One result per clock, latency 1.

Parameters:
- TOTAL_BITS, 7, word width of in1, in2 and out; must be ≥ 2.
- FRACTIONAL_BITS, 3, fractional bits of all three words; 0 ≤ FRACTIONAL_BITS < TOTAL_BITS.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle.
- in_signed  input  1  1 = treat in1/in2/out as two's-complement; 0 = unsigned.
- in1  input  TOTAL_BITS  multiplicand.
- in2  input  TOTAL_BITS  multiplier.
- out_valid  output  1  out/overflow valid.
- out  output  TOTAL_BITS  product in the same Q format.
- overflow  output  1  the true product did not fit in out.

Behaviour:
- Reset: while reset_n = 0, out = 0, out_valid = 0, overflow = 0, asynchronously. Outputs stay 0 until the first clk edge after release that samples in_valid = 1.
- Latency and throughput:
  - out_valid(n+1) = in_valid(n).
  - out and overflow load only when in_valid = 1; otherwise they hold their last value.
  - No backpressure; a new operation is accepted every cycle.
- Arithmetic:
  - Form the full 2*TOTAL_BITS product, signed or unsigned per in_signed.
  - Shift it right by FRACTIONAL_BITS: arithmetic shift when signed, logical when unsigned. This discards low bits, i.e. truncation toward −∞ and no rounding.
  - out = low TOTAL_BITS of the shifted product, so overflow wraps modulo 2^TOTAL_BITS.
- Overflow flag:
  - Unsigned: set if any shifted-product bit above TOTAL_BITS−1 is 1.
  - Signed: set if the bits above TOTAL_BITS−1 are not all equal to bit TOTAL_BITS−1.
- Edge cases:
  - Signed most-negative × −1 wraps and sets overflow.
  - Zero operand gives 0, no overflow.
- Reset asserted mid-operation: the pending result is discarded; out_valid = 0 immediately.
- Operand values are sampled only on the clk edge; in1/in2/in_signed may change freely between edges.

Optional Feature:
- Macro: FIXMUL_SATURATE_EN.
- Defined: on overflow, out clamps instead of wrapping.
  - Unsigned clamp: all ones.
  - Signed clamp: 0 1…1 for positive overflow, 1 0…0 for negative overflow.
  - The overflow flag still asserts.
- Undefined: wrap-around as above; no saturation logic is synthesised.

Decomposition:
- Package fixmul_pkg holds:
  - Default-width typedefs uq_t (logic [6:0]) and sq_t (logic signed [6:0]).
  - A product typedef of 2*TOTAL_BITS.
  - A function computing the signed and unsigned max/min clamp constants from TOTAL_BITS.
- One combinational sub-module, fixmul_core: inputs in1, in2, in_signed; outputs the shifted result and overflow, with optional saturation.
- The top level, fixmul, adds the input-valid gating, output registers and reset.

Test Plan (bench uses two instances, both TOTAL_BITS = 7: A with FRACTIONAL_BITS = 3, B with FRACTIONAL_BITS = 0; pulse in_valid one cycle, check the next cycle):
- A, unsigned:
  - 1.5 × 2.0: 7'b0001100 × 7'b0010000 → 7'b0011000 (3.0), overflow 0.
  - 15.0 × 0.5: 7'b1111000 × 7'b0000100 → 7'b0111100 (7.5), overflow 0.
  - 15.0 × 2.0: → 7'b1110000 (30 mod 16 = 14.0), overflow 1. With FIXMUL_SATURATE_EN → 7'b1111111.
- B, signed:
  - 3×5 → 15; −3×−5 → 15; 3×−5 → −15; −3×5 → −15; overflow 0 in all four.
  - 63×−1 → −63 and −32×2 → −64, overflow 0.
  - −64×−1 → −64 (7'b1000000), overflow 1.
- A, signed truncation: −0.125 × 0.5 (7'b1111111 × 7'b0000100) → 7'b1111111 (−0.125, floor), overflow 0.
- Control:
  - Back-to-back in_valid for 3 cycles yields 3 consecutive out_valid with the matching results.
  - in_valid = 0 holds out.
  - reset_n pulled low between an accepting edge and the result cycle forces out, out_valid and overflow to 0 immediately.

Source files
------------

// File: rtl/fixmul_pkg.sv
// fixmul_pkg: shared types and constants for the fixed-point multiplier.
// Default-width word/product typedefs plus a clamp-constant helper that the
// optional saturation path (FIXMUL_SATURATE_EN) uses.
package fixmul_pkg;

   localparam int TOTAL_BITS_DEF = 7;

   typedef logic        [TOTAL_BITS_DEF-1:0]   uq_t;
   typedef logic signed [TOTAL_BITS_DEF-1:0]   sq_t;
   typedef logic        [2*TOTAL_BITS_DEF-1:0] prod_t;

   // Clamp limits; only the low total_bits of each field are meaningful.
   typedef struct packed {
      logic [63:0] u_max;  // 1...1
      logic [63:0] s_max;  // 0 1...1
      logic [63:0] s_min;  // 1 0...0
   } clamp_t;

   function automatic clamp_t clamp_consts(input int unsigned total_bits);
      clamp_t c;
      c.u_max = (64'd1 << total_bits) - 64'd1;
      c.s_max = (64'd1 << (total_bits - 1)) - 64'd1;
      c.s_min = 64'd1 << (total_bits - 1);
      return c;
   endfunction

endpackage

// File: rtl/fixmul_core.sv
// fixmul_core: combinational fixed-point multiply, rescale and overflow
// detect. With FIXMUL_SATURATE_EN defined the result clamps on overflow;
// otherwise it wraps modulo 2^TOTAL_BITS.
module fixmul_core
   import fixmul_pkg::*;
#(
   parameter int TOTAL_BITS      = 7,
   parameter int FRACTIONAL_BITS = 3
) (
   input  logic                  in_signed,
   input  logic [TOTAL_BITS-1:0] in1,
   input  logic [TOTAL_BITS-1:0] in2,
   output logic [TOTAL_BITS-1:0] result,
   output logic                  overflow
);

   localparam int W  = TOTAL_BITS;
   localparam int PW = 2 * TOTAL_BITS;

`ifdef FIXMUL_SATURATE_EN
   localparam clamp_t CLAMP = clamp_consts(TOTAL_BITS);
`endif

   logic [PW-1:0] prod_u;
   logic [PW-1:0] prod_s;
   logic [PW-1:0] shifted;
   logic [W-1:0]  upper;

   // Full-width product, rescale by the fractional bits, then check that the
   // discarded high part is a pure zero/sign extension of the kept word.
   always_comb begin
      // NOTE: every output of this block is assigned up front on every path,
      // so no latch can be inferred.
      prod_u   = {{W{1'b0}}, in1} * {{W{1'b0}}, in2};
      prod_s   = $unsigned($signed({{W{in1[W-1]}}, in1}) *
                           $signed({{W{in2[W-1]}}, in2}));
      shifted  = '0;
      if (in_signed) begin
         // Arithmetic shift: truncation toward minus infinity.
         shifted = $unsigned($signed(prod_s) >>> FRACTIONAL_BITS);
      end else begin
         shifted = prod_u >> FRACTIONAL_BITS;
      end
      upper    = shifted[PW-1:W];
      overflow = in_signed ? (upper != {W{shifted[W-1]}}) : (|upper);
      result   = shifted[W-1:0];
`ifdef FIXMUL_SATURATE_EN
      if (overflow) begin
         if (!in_signed) begin
            result = CLAMP.u_max[W-1:0];
         end else if (shifted[PW-1]) begin
            result = CLAMP.s_min[W-1:0];
         end else begin
            result = CLAMP.s_max[W-1:0];
         end
      end
`endif
   end

endmodule

// File: rtl/fixmul.sv
// fixmul: registered fixed-point multiplier, latency 1, one result per clock.
// Optional saturation on overflow is enabled by defining FIXMUL_SATURATE_EN.
module fixmul
   import fixmul_pkg::*;
#(
   parameter int TOTAL_BITS      = 7,
   parameter int FRACTIONAL_BITS = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic                  in_signed,
   input  logic [TOTAL_BITS-1:0] in1,
   input  logic [TOTAL_BITS-1:0] in2,
   output logic                  out_valid,
   output logic [TOTAL_BITS-1:0] out,
   output logic                  overflow
);

   logic [TOTAL_BITS-1:0] core_result;
   logic                  core_overflow;

   logic                  out_valid_d, out_valid_q;
   logic [TOTAL_BITS-1:0] out_d, out_q;
   logic                  overflow_d, overflow_q;

   fixmul_core #(
      .TOTAL_BITS      (TOTAL_BITS),
      .FRACTIONAL_BITS (FRACTIONAL_BITS)
   ) u_core (
      .in_signed (in_signed),
      .in1       (in1),
      .in2       (in2),
      .result    (core_result),
      .overflow  (core_overflow)
   );

   // Next state: load a new result when operands are valid, else hold.
   always_comb begin
      out_valid_d = in_valid;
      out_d       = in_valid ? core_result   : out_q;
      overflow_d  = in_valid ? core_overflow : overflow_q;
   end

   // Output registers, cleared asynchronously so a pending result is dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         overflow_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep all flops updating from the
         // same pre-edge values regardless of statement order.
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         overflow_q  <= overflow_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_fixmul.sv
// tb_fixmul: scoreboard bench for fixmul. Instance A is Q7.3, instance B is
// Q7.0. Stimulus pushes expected results into per-instance queues; monitors
// pop and compare whenever out_valid is seen.
module tb_fixmul;

   typedef struct {
      logic [6:0] out;
      logic       ovf;
      int         cyc;
      string      nm;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;

   logic       in_valid_a = 1'b0, in_signed_a = 1'b0;
   logic [6:0] in1_a = '0, in2_a = '0;
   logic       out_valid_a, overflow_a;
   logic [6:0] out_a;

   logic       in_valid_b = 1'b0, in_signed_b = 1'b0;
   logic [6:0] in1_b = '0, in2_b = '0;
   logic       out_valid_b, overflow_b;
   logic [6:0] out_b;

   exp_t       sa[$];
   exp_t       sb[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         run_b = 0;
   int         max_run_b = 0;

   fixmul #(.TOTAL_BITS(7), .FRACTIONAL_BITS(3)) u_a (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid_a),
      .in_signed (in_signed_a),
      .in1       (in1_a),
      .in2       (in2_a),
      .out_valid (out_valid_a),
      .out       (out_a),
      .overflow  (overflow_a)
   );

   fixmul #(.TOTAL_BITS(7), .FRACTIONAL_BITS(0)) u_b (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid_b),
      .in_signed (in_signed_b),
      .in1       (in1_b),
      .in2       (in2_b),
      .out_valid (out_valid_b),
      .out       (out_b),
      .overflow  (overflow_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor A
   always @(negedge clk) begin
      if (reset_n && out_valid_a) begin
         if (sa.size() == 0) begin
            check("A unexpected out_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sa.pop_front();
            check({e.nm, " out"}, {25'd0, out_a}, {25'd0, e.out});
            check({e.nm, " ovf"}, {31'd0, overflow_a}, {31'd0, e.ovf});
            check({e.nm, " latency"}, cyc, e.cyc);
         end
      end
   end

   // Monitor B, also tracking the longest run of consecutive out_valid
   always @(negedge clk) begin
      if (reset_n && out_valid_b) begin
         run_b++;
         if (run_b > max_run_b) max_run_b = run_b;
         if (sb.size() == 0) begin
            check("B unexpected out_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.nm, " out"}, {25'd0, out_b}, {25'd0, e.out});
            check({e.nm, " ovf"}, {31'd0, overflow_b}, {31'd0, e.ovf});
            check({e.nm, " latency"}, cyc, e.cyc);
         end
      end else begin
         run_b = 0;
      end
   end

   task automatic issue_a(input logic sgn, input logic [6:0] a, input logic [6:0] b,
                          input logic [6:0] eo, input logic eov, input string nm);
      exp_t e;
      @(negedge clk);
      in_valid_a = 1'b1; in_signed_a = sgn; in1_a = a; in2_a = b;
      e.out = eo; e.ovf = eov; e.cyc = cyc + 1; e.nm = nm;
      sa.push_back(e);
   endtask

   task automatic issue_b(input logic sgn, input logic [6:0] a, input logic [6:0] b,
                          input logic [6:0] eo, input logic eov, input string nm);
      exp_t e;
      @(negedge clk);
      in_valid_b = 1'b1; in_signed_b = sgn; in1_b = a; in2_b = b;
      e.out = eo; e.ovf = eov; e.cyc = cyc + 1; e.nm = nm;
      sb.push_back(e);
   endtask

   // Drop both valids and scramble operands for n cycles.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid_a = 1'b0; in_valid_b = 1'b0;
         in1_a = 7'($urandom); in2_a = 7'($urandom); in_signed_a = 1'($urandom);
         in1_b = 7'($urandom); in2_b = 7'($urandom); in_signed_b = 1'($urandom);
      end
   endtask

   initial begin
      logic [6:0] wrap_exp;
`ifdef FIXMUL_SATURATE_EN
      wrap_exp = 7'b1111111;
`else
      wrap_exp = 7'b1110000;
`endif
      #1;
      check("reset A out_valid", {31'd0, out_valid_a}, 32'd0);
      check("reset A out", {25'd0, out_a}, 32'd0);
      check("reset A ovf", {31'd0, overflow_a}, 32'd0);
      check("reset B out_valid", {31'd0, out_valid_b}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      idle(2);
      check("post-reset A out idle", {25'd0, out_a}, 32'd0);

      // A: unsigned Q7.3
      issue_a(1'b0, 7'b0001100, 7'b0010000, 7'b0011000, 1'b0, "A u 1.5x2.0");
      idle(1);
      issue_a(1'b0, 7'b1111000, 7'b0000100, 7'b0111100, 1'b0, "A u 15x0.5");
      idle(3);
      check("A hold out", {25'd0, out_a}, {25'd0, 7'b0111100});
      check("A hold out_valid", {31'd0, out_valid_a}, 32'd0);
      issue_a(1'b0, 7'b1111000, 7'b0010000, wrap_exp, 1'b1, "A u 15x2.0 wrap");
      idle(1);
      issue_a(1'b1, 7'b1111111, 7'b0000100, 7'b1111111, 1'b0, "A s -0.125x0.5");
      idle(1);
      issue_a(1'b0, 7'b0000000, 7'b1111111, 7'b0000000, 1'b0, "A u zero");
      idle(1);

      // B: signed Q7.0 singles
      issue_b(1'b1, 7'h03, 7'h05, 7'h0F, 1'b0, "B s 3x5");
      idle(1);
      issue_b(1'b1, 7'h7D, 7'h7B, 7'h0F, 1'b0, "B s -3x-5");
      idle(1);
      issue_b(1'b1, 7'h03, 7'h7B, 7'h71, 1'b0, "B s 3x-5");
      idle(1);
      issue_b(1'b1, 7'h7D, 7'h05, 7'h71, 1'b0, "B s -3x5");
      idle(1);
      // B: back-to-back burst
      issue_b(1'b1, 7'h3F, 7'h7F, 7'h41, 1'b0, "B s 63x-1");
      issue_b(1'b1, 7'h60, 7'h02, 7'h40, 1'b0, "B s -32x2");
      issue_b(1'b1, 7'h40, 7'h7F, 7'h40, 1'b1, "B s -64x-1");
      idle(3);
      check("B burst run length", max_run_b, 32'd3);

      // Reset between accepting edge and result cycle
      issue_a(1'b0, 7'b0001100, 7'b0010000, 7'b0011000, 1'b0, "A discarded");
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      in_valid_a = 1'b0;
      #1;
      check("mid-reset A out_valid", {31'd0, out_valid_a}, 32'd0);
      check("mid-reset A out", {25'd0, out_a}, 32'd0);
      check("mid-reset A ovf", {31'd0, overflow_a}, 32'd0);
      sa.delete();
      @(negedge clk);
      reset_n = 1'b1;
      idle(2);
      check("A post-reset out", {25'd0, out_a}, 32'd0);

      check("A queue drained", sa.size(), 32'd0);
      check("B queue drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
